irq_prio_ctrl: RTL and testbench

- Parametrised, registered successor to the team's combinational multi-bus interrupt priority encoder.
- Latches requests from NBUS request buses of NCH channels each into a pending register, gated by per-channel enables.
- Arbitrates pending requests by fixed priority and presents one winner at a time through a valid/ack handshake.
- Sits between peripheral request lines and the CPU interrupt interface.

---
 rtl/irq_prio_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_prio_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_prio_ctrl.sv
// Registered multi-bus interrupt priority controller: latches enabled requests into a
// pending register and presents the highest-priority one through a valid/ack handshake.
module irq_prio_ctrl #(
  parameter int NCH  = 9,
  parameter int NBUS = 3,
  parameter bit EDGE = 1'b0,
  localparam int BW  = (NBUS > 1) ? $clog2(NBUS) : 1,
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUS*NCH-1:0]  req_i,
  input  logic [NCH-1:0]       en_i,
  input  logic                 irq_ack_i,
  output logic                 irq_valid_o,
  output logic [BW-1:0]        irq_bus_o,
  output logic [IDW-1:0]       irq_id_o,
  output logic [NBUS-1:0]      bus_active_o,
  output logic [NBUS*NCH-1:0]  pending_o
);

  localparam int NTOT = NBUS * NCH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NTOT-1:0]   req_q;
  logic [NTOT-1:0]   pending_q, pending_d;
  logic [BW-1:0]     bus_q, bus_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [NBUS-1:0]   bus_active_q, bus_active_d;

  logic [NTOT-1:0]   en_rep_s;
  logic [NTOT-1:0]   set_vec_s;
  logic [NTOT-1:0]   clr_vec_s;
  logic [NTOT-1:0]   elig_s;
  logic              ack_fire_s;
  logic              win_found_s;
  logic [BW-1:0]     win_bus_s;
  logic [IDW-1:0]    win_id_s;

  // Pending update: set has priority over the handshake clear of the granted bit.
  always_comb begin
    en_rep_s   = {NBUS{en_i}};
    ack_fire_s = (state_q == ST_GRANT) & irq_ack_i;
    set_vec_s  = req_i & en_rep_s & (EDGE ? ~req_q : {NTOT{1'b1}});
    clr_vec_s  = '0;
    for (int k = 0; k < NTOT; k++) begin
      clr_vec_s[k] = ack_fire_s & ((int'(bus_q) * NCH + int'(id_q)) == k);
    end
    pending_d = (pending_q & ~clr_vec_s) | set_vec_s;
    elig_s    = pending_q & en_rep_s;
    for (int b = 0; b < NBUS; b++) begin
      bus_active_d[b] = |elig_s[b*NCH +: NCH];
    end
  end

  // Fixed-priority pick; scanning downwards lets the lowest bus/channel overwrite last.
  always_comb begin
    win_found_s = 1'b0;
    win_bus_s   = '0;
    win_id_s    = '0;
    for (int b = NBUS - 1; b >= 0; b--) begin
      for (int c = NCH - 1; c >= 0; c--) begin
        win_found_s = win_found_s | elig_s[b*NCH + c];
        win_bus_s   = elig_s[b*NCH + c] ? BW'(b)  : win_bus_s;
        win_id_s    = elig_s[b*NCH + c] ? IDW'(c) : win_id_s;
      end
    end
  end

  // Handshake FSM: winner is frozen for the whole grant.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          state_d = ST_GRANT;
          bus_d   = win_bus_s;
          id_d    = win_id_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (irq_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; req history loads live requests in reset to suppress a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_q        <= req_i;
      pending_q    <= '0;
      bus_q        <= '0;
      id_q         <= '0;
      bus_active_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_i;
      pending_q    <= pending_d;
      bus_q        <= bus_d;
      id_q         <= id_d;
      bus_active_q <= bus_active_d;
    end
  end

  assign irq_valid_o  = (state_q == ST_GRANT);
  assign irq_bus_o    = bus_q;
  assign irq_id_o     = id_q;
  assign bus_active_o = bus_active_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Scoreboard bench for irq_prio_ctrl: one level-mode and one edge-mode instance,
// expected grants queued by the stimulus and popped by per-instance monitors.
module tb_irq_prio_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_l, rst_e;
  logic [26:0] req_l, req_e;
  logic [8:0]  en_l, en_e;
  logic        ack_l, ack_e;
  logic        valid_l, valid_e;
  logic [1:0]  bus_l, bus_e;
  logic [3:0]  id_l, id_e;
  logic [2:0]  act_l, act_e;
  logic [26:0] pend_l, pend_e;

  logic [5:0]  q_l[$];
  logic [5:0]  q_e[$];
  logic        prev_l = 1'b0;
  logic        prev_e = 1'b0;

  irq_prio_ctrl #(.NCH(9), .NBUS(3), .EDGE(1'b0)) u_lvl (
    .clk(clk), .rst(rst_l), .req_i(req_l), .en_i(en_l), .irq_ack_i(ack_l),
    .irq_valid_o(valid_l), .irq_bus_o(bus_l), .irq_id_o(id_l),
    .bus_active_o(act_l), .pending_o(pend_l)
  );

  irq_prio_ctrl #(.NCH(9), .NBUS(3), .EDGE(1'b1)) u_edg (
    .clk(clk), .rst(rst_e), .req_i(req_e), .en_i(en_e), .irq_ack_i(ack_e),
    .irq_valid_o(valid_e), .irq_bus_o(bus_e), .irq_id_o(id_e),
    .bus_active_o(act_e), .pending_o(pend_e)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Level-instance monitor: every rising valid must match the head of the queue.
  always @(negedge clk) begin
    if (valid_l && !prev_l) begin
      if (q_l.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_l: unexpected grant bus=%0d id=%0d, none expected", bus_l, id_l);
      end else begin
        chk("grant_l", 32'({bus_l, id_l}), 32'(q_l.pop_front()));
      end
    end
    prev_l = valid_l;
  end

  // Edge-instance monitor.
  always @(negedge clk) begin
    if (valid_e && !prev_e) begin
      if (q_e.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL grant_e: unexpected grant bus=%0d id=%0d, none expected", bus_e, id_e);
      end else begin
        chk("grant_e", 32'({bus_e, id_e}), 32'(q_e.pop_front()));
      end
    end
    prev_e = valid_e;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b1; rst_e = 1'b1;
    req_l = '1;   req_e = '1;
    en_l  = '1;   en_e  = '1;
    ack_l = 1'b0; ack_e = 1'b0;

    // Reset with all requests high
    repeat (3) begin
      nxt(); mid();
      chk("rst_valid_l", 32'(valid_l), 32'd0);
      chk("rst_pend_l",  32'(pend_l),  32'd0);
      chk("rst_act_l",   32'(act_l),   32'd0);
      chk("rst_busid_l", 32'({bus_l, id_l}), 32'd0);
      chk("rst_valid_e", 32'(valid_e), 32'd0);
      chk("rst_pend_e",  32'(pend_e),  32'd0);
    end
    rst_l = 1'b0; rst_e = 1'b0; req_l = '0;
    // Edge mode: requests held through release must not produce an edge
    repeat (4) begin
      nxt(); mid();
      chk("rel_valid_e", 32'(valid_e), 32'd0);
      chk("rel_pend_e",  32'(pend_e),  32'd0);
    end
    req_e = '0;
    nxt();

    // Single level request bus1 ch4
    req_l[13] = 1'b1; q_l.push_back({2'd1, 4'd4});
    mid(); chk("single_c0_valid", 32'(valid_l), 32'd0);
    nxt(); mid();
    chk("single_c1_pend", 32'(pend_l[13]), 32'd1);
    chk("single_c1_valid", 32'(valid_l), 32'd0);
    nxt(); mid(); chk("single_c2_valid", 32'(valid_l), 32'd1);
    nxt(); req_l = '0;
    nxt();
    nxt(); ack_l = 1'b1; mid(); chk("single_c5_valid", 32'(valid_l), 32'd1);
    nxt(); ack_l = 1'b0; mid();
    chk("single_c6_valid", 32'(valid_l), 32'd0);
    chk("single_c6_pend",  32'(pend_l),  32'd0);
    chk("single_c6_hold",  32'({bus_l, id_l}), 32'({2'd1, 4'd4}));
    nxt();

    // Priority order (0,3) (0,8) (2,0)
    req_l[3] = 1'b1; req_l[8] = 1'b1; req_l[18] = 1'b1;
    q_l.push_back({2'd0, 4'd3}); q_l.push_back({2'd0, 4'd8}); q_l.push_back({2'd2, 4'd0});
    nxt(); req_l = '0; mid(); chk("prio_c1_act", 32'(act_l), 32'd0);
    nxt(); mid();
    chk("prio_c2_valid", 32'(valid_l), 32'd1);
    chk("prio_c2_act",   32'(act_l),   32'b101);
    for (int g = 0; g < 3; g++) begin
      nxt(); nxt(); ack_l = 1'b1; mid(); chk("prio_ack_valid", 32'(valid_l), 32'd1);
      nxt(); ack_l = 1'b0; mid(); chk("prio_gap_valid", 32'(valid_l), 32'd0);
      nxt(); mid();
      if (g < 2) begin
        chk("prio_regrant_valid", 32'(valid_l), 32'd1);
      end else begin
        chk("prio_end_valid", 32'(valid_l), 32'd0);
        chk("prio_end_pend",  32'(pend_l),  32'd0);
        chk("prio_end_act",   32'(act_l),   32'd0);
      end
    end

    // Masking: channel 3 disabled
    en_l = 9'h1F7;
    nxt(); req_l[3] = 1'b1;
    nxt(); req_l = '0;
    repeat (3) begin
      mid();
      chk("mask_valid", 32'(valid_l), 32'd0);
      chk("mask_act",   32'(act_l),   32'd0);
      chk("mask_pend",  32'(pend_l),  32'd0);
      nxt();
    end
    req_l[3] = 1'b1;
    nxt(); nxt(); mid(); chk("mask_held_valid", 32'(valid_l), 32'd0);
    en_l = 9'h1FF; q_l.push_back({2'd0, 4'd3});
    nxt(); mid(); chk("unmask_e1_valid", 32'(valid_l), 32'd0);
    nxt(); mid(); chk("unmask_e2_valid", 32'(valid_l), 32'd1);
    req_l = '0;
    nxt(); ack_l = 1'b1;
    nxt(); ack_l = 1'b0; mid();
    chk("unmask_done_valid", 32'(valid_l), 32'd0);
    chk("unmask_done_pend",  32'(pend_l),  32'd0);

    // Edge mode: bit 20 held 10 cycles -> one grant
    nxt(); req_e[20] = 1'b1; q_e.push_back({2'd2, 4'd2});
    nxt(); nxt(); mid(); chk("edge_c2_valid", 32'(valid_e), 32'd1);
    nxt(); nxt(); ack_e = 1'b1;
    nxt(); ack_e = 1'b0;
    repeat (5) begin
      mid();
      chk("edge_held_valid", 32'(valid_e), 32'd0);
      chk("edge_held_pend",  32'(pend_e),  32'd0);
      nxt();
    end
    req_e = '0;
    nxt(); req_e[20] = 1'b1; q_e.push_back({2'd2, 4'd2});
    nxt(); nxt(); mid(); chk("edge_fresh_valid", 32'(valid_e), 32'd1);
    req_e = '0;
    nxt(); ack_e = 1'b1;
    nxt(); ack_e = 1'b0; mid();
    chk("edge_fresh_done_valid", 32'(valid_e), 32'd0);
    chk("edge_fresh_done_pend",  32'(pend_e),  32'd0);

    // Set/clear collision on bit 10, then reset mid-grant
    nxt(); req_e[10] = 1'b1; q_e.push_back({2'd1, 4'd1});
    nxt(); req_e = '0;
    nxt(); mid(); chk("coll_c2_valid", 32'(valid_e), 32'd1);
    nxt(); req_e[10] = 1'b1; ack_e = 1'b1; q_e.push_back({2'd1, 4'd1});
    nxt(); req_e = '0; ack_e = 1'b0; mid();
    chk("coll_c4_valid", 32'(valid_e), 32'd0);
    chk("coll_c4_pend",  32'(pend_e[10]), 32'd1);
    nxt(); mid(); chk("coll_c5_valid", 32'(valid_e), 32'd1);
    nxt(); rst_e = 1'b1; mid(); chk("midrst_pre_valid", 32'(valid_e), 32'd1);
    nxt(); rst_e = 1'b0; mid();
    chk("midrst_valid", 32'(valid_e), 32'd0);
    chk("midrst_pend",  32'(pend_e),  32'd0);
    chk("midrst_act",   32'(act_e),   32'd0);
    repeat (3) begin
      nxt(); mid();
      chk("post_rst_valid", 32'(valid_e), 32'd0);
    end

    chk("queue_l_empty", 32'(q_l.size()), 32'd0);
    chk("queue_e_empty", 32'(q_e.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
